vram_arbiter: RTL and testbench

- Shares the single-port text VRAM (2048x8, address {5'row, 6'col}) between NREQ requesters: the character writer, the block-operation engine (scroll/clear) and the host readback path.
- Grants one requester per access using round-robin priority. A requester may lock ownership for bursts such as scroll or clear.
- Drives the VRAM pins directly and routes read data back to the requester that issued the read.
- Sits between the terminal control logic and the VRAM primitive.

---
 rtl/vram_pkg.sv | 28 ++
 rtl/vram_arbiter_rr_pick.sv | 31 +++
 rtl/vram_arbiter.sv | 118 +++++++++++
 tb/tb_vram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants for the text VRAM: geometry, screen bounds and requester slots.
// Also holds the round-robin pointer helper.
package vram_pkg;

    localparam int VRAM_AW   = 11;
    localparam int VRAM_DW   = 8;
    localparam int ROW_W     = 5;
    localparam int COL_W     = 6;
    localparam int FIRST_ROW = 0;
    localparam int LAST_ROW  = 16;
    localparam int FIRST_COL = 0;
    localparam int LAST_COL  = 59;

    // Pointer width covers the supported range of 2..4 requesters.
    localparam int PTR_W = 2;

    typedef enum logic [PTR_W-1:0] {
        REQ_WRITER  = 2'd0,
        REQ_BLOCKOP = 2'd1,
        REQ_HOST    = 2'd2
    } req_id_e;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after the pointer wins.
module rr_pick
    import vram_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_win,
    output logic             o_any
);

    logic w_found;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        o_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && i_req[j] && (((int'(i_ptr) + i) % N) == j)) begin
                    o_win[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin arbiter for the single-port text VRAM, with lockable bursts,
// a per-ownership lock limit and routing of read data to the issuing requester.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = VRAM_AW,
    parameter int DW       = VRAM_DW,
    parameter int LOCK_MAX = 2048
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_lock,
    input  logic [NREQ-1:0]    i_we,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ*DW-1:0] i_din,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_rvalid,
    output logic [DW-1:0]      o_rdata,
    output logic               o_lock_break,
    output logic               o_vram_clk,
    output logic               o_vram_ce,
    output logic               o_vram_wre,
    output logic [AW-1:0]      o_vram_addr,
    output logic [DW-1:0]      o_vram_din,
    input  logic [DW-1:0]      i_vram_dout
);

    localparam int              CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (LOCK_MAX > 0) ? CNT_W'(LOCK_MAX - 1) : '0;
    localparam bit              LIMIT_EN = (LOCK_MAX > 0);

    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_rvalid;
    logic             r_lock_break;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic [PTR_W-1:0] w_own_idx;
    logic             w_own_req, w_own_lock, w_own_we;
    logic [AW-1:0]    w_own_addr;
    logic [DW-1:0]    w_own_din;
    logic             w_owned, w_access, w_others, w_at_limit;
    logic             w_lock_hold, w_keep, w_break, w_any;
    logic [PTR_W-1:0] w_pick_ptr;
    logic [NREQ-1:0]  w_pick;

    // Owner's request fields; requester 0 is presented while idle.
    always_comb begin
        w_own_idx  = PTR_W'(REQ_WRITER);
        w_own_req  = i_req[0];
        w_own_lock = i_lock[0];
        w_own_we   = i_we[0];
        w_own_addr = i_addr[0 +: AW];
        w_own_din  = i_din[0 +: DW];
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_own_idx  = PTR_W'(i);
                w_own_req  = i_req[i];
                w_own_lock = i_lock[i];
                w_own_we   = i_we[i];
                w_own_addr = i_addr[i*AW +: AW];
                w_own_din  = i_din[i*DW +: DW];
            end
        end
    end

    assign w_owned     = |r_gnt;
    assign w_access    = w_owned & w_own_req;
    assign w_others    = |(i_req & ~r_gnt);
    assign w_at_limit  = LIMIT_EN && (r_cnt == CNT_LAST);
    assign w_lock_hold = w_access & w_own_lock;
    assign w_break     = w_lock_hold & w_at_limit & w_others;
    assign w_keep      = w_lock_hold & ~w_break;

    // A current owner always yields to the requester after it.
    assign w_pick_ptr = w_owned ? ptr_next(w_own_idx, NREQ) : r_ptr;

    rr_pick #(.N(NREQ)) u_pick (
        .i_req (i_req),
        .i_ptr (w_pick_ptr),
        .o_win (w_pick),
        .o_any (w_any)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_lock_break <= 1'b0;
            r_ptr        <= '0;
            r_cnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            r_lock_break <= w_break;
            r_rvalid     <= (w_access && !w_own_we) ? r_gnt : '0;
            if (w_owned) r_ptr <= ptr_next(w_own_idx, NREQ);
            if (w_keep) begin
                if (!w_at_limit) r_cnt <= r_cnt + 1'b1;
            end else begin
                r_gnt <= w_any ? w_pick : '0;
                r_cnt <= '0;
            end
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rvalid     = r_rvalid;
    assign o_rdata      = i_vram_dout;
    assign o_lock_break = r_lock_break;
    assign o_vram_clk   = i_clk;
    assign o_vram_ce    = w_access;
    assign o_vram_wre   = w_access & w_own_we;
    assign o_vram_addr  = w_own_addr;
    assign o_vram_din   = w_own_din;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a
// cycle model of the arbitration rules, on a default instance and one with LOCK_MAX=4.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int N     = 3;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int LIM_A = 2048;
    localparam int LIM_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0, lock = '0, we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] din = '0;

    logic [N-1:0]  gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b, vdin_a, vdin_b, vdout;
    logic [AW-1:0] vaddr_a, vaddr_b;
    logic          brk_a, brk_b, vclk_a, vclk_b, ce_a, ce_b, wre_a, wre_b;

    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .LOCK_MAX(LIM_A)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr(addr), .i_din(din), .o_gnt(gnt_a), .o_rvalid(rvalid_a),
        .o_rdata(rdata_a), .o_lock_break(brk_a), .o_vram_clk(vclk_a),
        .o_vram_ce(ce_a), .o_vram_wre(wre_a), .o_vram_addr(vaddr_a),
        .o_vram_din(vdin_a), .i_vram_dout(vdout)
    );

    vram_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .LOCK_MAX(LIM_B)) dut_lim (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr(addr), .i_din(din), .o_gnt(gnt_b), .o_rvalid(rvalid_b),
        .o_rdata(rdata_b), .o_lock_break(brk_b), .o_vram_clk(vclk_b),
        .o_vram_ce(ce_b), .o_vram_wre(wre_b), .o_vram_addr(vaddr_b),
        .o_vram_din(vdin_b), .i_vram_dout(vdout)
    );

    // VRAM stand-in driven by the default instance, 1-cycle read latency.
    logic [DW-1:0] vram [2048];
    always @(posedge clk) begin
        if (ce_a) begin
            if (wre_a) vram[vaddr_a] <= vdin_a;
            else       vdout <= vram[vaddr_a];
        end
    end

    // Reference model: owner (-1 = idle), pointer, lock count and a memory image.
    int            m_owner [2];
    int            m_ptr   [2];
    int            m_cnt   [2];
    logic [N-1:0]  m_rvalid[2];
    logic          m_brk   [2];
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] shadow [2048];

    task automatic model_step(input int m);
        int o, nxt, start, lm;
        bit others, keep;
        lm = (m == 0) ? LIM_A : LIM_B;
        o  = m_owner[m];
        m_rvalid[m] = '0;
        m_brk[m]    = 1'b0;
        if (o >= 0 && req[o]) begin
            if (we[o]) begin
                if (m == 0) shadow[addr[o*AW +: AW]] = din[o*DW +: DW];
            end else begin
                m_rvalid[m][o] = 1'b1;
                if (m == 0) m_rdata = shadow[addr[o*AW +: AW]];
            end
        end
        others = 1'b0;
        for (int k = 0; k < N; k++) if (req[k] && k != o) others = 1'b1;
        keep = 1'b0;
        if (o >= 0 && req[o] && lock[o]) begin
            if (lm != 0 && m_cnt[m] >= lm - 1 && others) m_brk[m] = 1'b1;
            else keep = 1'b1;
        end
        if (keep) begin
            if (lm == 0 || m_cnt[m] < lm - 1) m_cnt[m]++;
        end else begin
            start = (o >= 0) ? (o + 1) % N : m_ptr[m];
            nxt   = -1;
            for (int i = 0; i < N; i++) if (nxt < 0 && req[(start + i) % N]) nxt = (start + i) % N;
            m_owner[m] = nxt;
            m_cnt[m]   = 0;
        end
        if (o >= 0) m_ptr[m] = (o + 1) % N;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_owner[m] = -1; m_ptr[m] = 0; m_cnt[m] = 0;
                m_rvalid[m] = '0; m_brk[m] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    function automatic logic [N-1:0] e_gnt(input int m);
        return (m_owner[m] >= 0) ? (N'(1) << m_owner[m]) : '0;
    endfunction

    function automatic logic e_ce(input int m);
        return (m_owner[m] >= 0) && req[m_owner[m]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = '0; lock = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++; if (gnt_a !== '0 || gnt_b !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b/%b want 000", gnt_a, gnt_b); end
        n_checks++; if (rvalid_a !== '0 || rvalid_b !== '0) begin n_fail++; $display("FAIL reset_rvalid: got %b/%b want 000", rvalid_a, rvalid_b); end
        n_checks++; if (brk_a !== 1'b0 || brk_b !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b/%b want 0", brk_a, brk_b); end
        n_checks++; if (ce_a !== 1'b0 || wre_a !== 1'b0) begin n_fail++; $display("FAIL reset_ce_wre: got ce=%b wre=%b want 0", ce_a, wre_a); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (vclk_a !== clk || vclk_b !== clk) begin n_fail++; $display("FAIL vram_clk: got %b/%b want %b", vclk_a, vclk_b, clk); end
        step();
    endtask

    task automatic test_single_write();
        reset_dut();
        we[0] = 1'b1; addr[0 +: AW] = 11'h041; din[0 +: DW] = 8'h41; req[0] = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL wr_latency: got %b want 000", gnt_a); end
        step();
        @(negedge clk);
        n_checks++; if (gnt_a !== 3'b001) begin n_fail++; $display("FAIL wr_gnt: got %b want 001", gnt_a); end
        n_checks++; if (ce_a !== 1'b1 || wre_a !== 1'b1) begin n_fail++; $display("FAIL wr_ce_wre: got ce=%b wre=%b want 1 1", ce_a, wre_a); end
        n_checks++; if (vaddr_a !== 11'h041 || vdin_a !== 8'h41) begin n_fail++; $display("FAIL wr_addr_din: got %h %h want 041 41", vaddr_a, vdin_a); end
        step();
        req[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (ce_a !== 1'b0) begin n_fail++; $display("FAIL wr_ce_drop: got %b want 0", ce_a); end
        step(); step();
    endtask

    task automatic test_read_return();
        logic [AW-1:0] ra [2];
        logic [DW-1:0] rd [2];
        ra[0] = 11'h7FF; rd[0] = 8'h5A;
        ra[1] = 11'h041; rd[1] = 8'h41;
        for (int i = 0; i < 2; i++) begin
            reset_dut();
            we[2] = 1'b0; addr[2*AW +: AW] = ra[i]; req[2] = 1'b1;
            step();
            @(negedge clk);
            n_checks++; if (gnt_a !== 3'b100 || ce_a !== 1'b1 || wre_a !== 1'b0) begin n_fail++; $display("FAIL rd_gnt[%0d]: got gnt=%b ce=%b wre=%b want 100 1 0", i, gnt_a, ce_a, wre_a); end
            step();
            req[2] = 1'b0;
            @(negedge clk);
            n_checks++; if (rvalid_a !== 3'b100) begin n_fail++; $display("FAIL rd_rvalid[%0d]: got %b want 100", i, rvalid_a); end
            n_checks++; if (rdata_a !== rd[i] || rdata_b !== rd[i]) begin n_fail++; $display("FAIL rd_data[%0d]: got %h/%h want %h", i, rdata_a, rdata_b, rd[i]); end
            step(); step();
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq [6];
        seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        reset_dut();
        we = '0; req = 3'b111;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (gnt_a !== seq[i] || ce_a !== 1'b1) begin n_fail++; $display("FAIL rr_seq[%0d]: got gnt=%b ce=%b want %b 1", i, gnt_a, ce_a, seq[i]); end
            if (i > 0) begin
                n_checks++; if (rvalid_a !== seq[i-1]) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rvalid_a, seq[i-1]); end
            end
            step();
        end
        req = '0;
        step(); step();
    endtask

    task automatic test_lock_burst();
        reset_dut();
        we = 3'b010; req = 3'b010; lock = 3'b010;
        step();
        req[0] = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c == 10) lock[1] = 1'b0;
            if (c == 11) req[1] = 1'b0;
            @(negedge clk);
            if (c <= 10) begin
                n_checks++; if (gnt_a !== 3'b010) begin n_fail++; $display("FAIL burst_hold c%0d: got %b want 010", c, gnt_a); end
            end else begin
                n_checks++; if (gnt_a !== 3'b001) begin n_fail++; $display("FAIL burst_handoff: got %b want 001", gnt_a); end
            end
            n_checks++; if (brk_a !== 1'b0) begin n_fail++; $display("FAIL burst_no_break c%0d: got %b want 0", c, brk_a); end
            if (c <= 4) begin
                n_checks++; if (gnt_b !== 3'b010 || brk_b !== 1'b0) begin n_fail++; $display("FAIL limit_hold c%0d: got gnt=%b brk=%b want 010 0", c, gnt_b, brk_b); end
            end else if (c == 5) begin
                n_checks++; if (gnt_b !== 3'b001 || brk_b !== 1'b1) begin n_fail++; $display("FAIL limit_break: got gnt=%b brk=%b want 001 1", gnt_b, brk_b); end
            end
            step();
        end
        req = '0; lock = '0;
        step(); step();
    endtask

    task automatic test_lock_hold();
        reset_dut();
        we = '0; req = 3'b010; lock = 3'b010;
        step();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_checks++; if (gnt_b !== 3'b010 || brk_b !== 1'b0) begin n_fail++; $display("FAIL lock_saturate c%0d: got gnt=%b brk=%b want 010 0", c, gnt_b, brk_b); end
            step();
        end
        req = '0; lock = '0;
        step(); step();
    endtask

    task automatic test_reset_mid_read();
        reset_dut();
        we[2] = 1'b0; addr[2*AW +: AW] = 11'h7FF; req[2] = 1'b1;
        step();
        @(negedge clk);
        n_checks++; if (gnt_a !== 3'b100) begin n_fail++; $display("FAIL mid_gnt: got %b want 100", gnt_a); end
        step();
        req[2] = 1'b0;
        n_checks++; if (rvalid_a !== 3'b100) begin n_fail++; $display("FAIL mid_rvalid_pre: got %b want 100", rvalid_a); end
        rst = 1'b1;
        #1;
        n_checks++; if (rvalid_a !== 3'b000 || gnt_a !== 3'b000 || ce_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got rvalid=%b gnt=%b ce=%b want 000 000 0", rvalid_a, gnt_a, ce_a); end
        @(posedge clk);
        #1 rst = 1'b0;
        req = 3'b111;
        step();
        @(negedge clk);
        n_checks++; if (gnt_a !== 3'b001) begin n_fail++; $display("FAIL mid_first_gnt: got %b want 001", gnt_a); end
        req = '0;
        step(); step();
    endtask

    task automatic test_random();
        logic [N-1:0] acc;
        int o;
        reset_dut();
        acc = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if ((!req[k] && $urandom_range(0, 2) == 0) || (acc[k] && $urandom_range(0, 3) != 0)) begin
                    req[k]  = 1'b1;
                    lock[k] = ($urandom_range(0, 3) != 0);
                    we[k]   = $urandom_range(0, 1) == 1;
                    addr[k*AW +: AW] = 11'($urandom_range(0, 15));
                    din[k*DW +: DW]  = 8'($urandom);
                end else if (acc[k]) begin
                    req[k] = 1'b0; lock[k] = 1'b0;
                end
            end
            @(negedge clk);
            o = m_owner[0];
            n_checks++; if (gnt_a !== e_gnt(0)) begin n_fail++; $display("FAIL rnd_gnt_a c%0d: got %b want %b", c, gnt_a, e_gnt(0)); end
            n_checks++; if (gnt_b !== e_gnt(1)) begin n_fail++; $display("FAIL rnd_gnt_b c%0d: got %b want %b", c, gnt_b, e_gnt(1)); end
            n_checks++; if (rvalid_a !== m_rvalid[0] || rvalid_b !== m_rvalid[1]) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b/%b want %b/%b", c, rvalid_a, rvalid_b, m_rvalid[0], m_rvalid[1]); end
            n_checks++; if (brk_a !== m_brk[0] || brk_b !== m_brk[1]) begin n_fail++; $display("FAIL rnd_break c%0d: got %b/%b want %b/%b", c, brk_a, brk_b, m_brk[0], m_brk[1]); end
            n_checks++; if (ce_a !== e_ce(0) || ce_b !== e_ce(1)) begin n_fail++; $display("FAIL rnd_ce c%0d: got %b/%b want %b/%b", c, ce_a, ce_b, e_ce(0), e_ce(1)); end
            if (e_ce(0)) begin
                n_checks++; if (wre_a !== we[o] || vaddr_a !== addr[o*AW +: AW] || vdin_a !== din[o*DW +: DW])
                    begin n_fail++; $display("FAIL rnd_pins c%0d: got wre=%b addr=%h din=%h want %b %h %h", c, wre_a, vaddr_a, vdin_a, we[o], addr[o*AW +: AW], din[o*DW +: DW]); end
            end
            if (m_rvalid[0] != '0) begin
                n_checks++; if (rdata_a !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata_a, m_rdata); end
            end
            acc = e_gnt(0) & req;
            step();
        end
        req = '0; lock = '0;
        step(); step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            vram[i]   = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        vram[11'h7FF]   = 8'h5A;
        shadow[11'h7FF] = 8'h5A;
        test_reset();
        test_single_write();
        test_read_return();
        test_round_robin();
        test_lock_burst();
        test_lock_hold();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
